// File: rtl/multichannel_debounce_pkg.sv
// -----------------------------------------------------------------------------
// multichannel_debounce_pkg
//
// Purpose:
//   Shared constants and helpers for the multichannel debouncer: a constant
//   clog2 function, a counter-width helper, default debounce/hold lengths and
//   the counter widths those defaults imply.
//
// Contents:
//   DEFAULT_DEBOUNCE_CYCLES  default number of differing samples to accept a change
//   DEFAULT_HOLD_CYCLES      default long-press length in cycles
//   clog2(value)             ceil(log2(value)), 0 for value <= 1
//   cnt_width(max_count)     bits needed to hold 0..max_count, never below 1
//   DEFAULT_DEB_CNT_W        debounce counter width for the default length
//   DEFAULT_HOLD_CNT_W       hold counter width for the default length
// -----------------------------------------------------------------------------
package multichannel_debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 20;
    localparam int DEFAULT_HOLD_CYCLES     = 1000;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Counters are sized to reach max_count itself, hence the +1.
    function automatic int cnt_width(input int max_count);
        int width;
        width = clog2(max_count + 1);
        return (width < 1) ? 1 : width;
    endfunction

    localparam int DEFAULT_DEB_CNT_W  = cnt_width(DEFAULT_DEBOUNCE_CYCLES);
    localparam int DEFAULT_HOLD_CNT_W = cnt_width(DEFAULT_HOLD_CYCLES);

endpackage

// File: rtl/multichannel_debounce_channel.sv
// -----------------------------------------------------------------------------
// multichannel_debounce_channel
//
// Purpose:
//   One debounce channel: a SYNC_DEPTH-flop synchronizer, polarity
//   correction, a counter-based debouncer that accepts a change after
//   DEBOUNCE_CYCLES consecutive differing samples, registered one-cycle
//   rose/fell/changed pulses and, when MULTICHANNEL_DEBOUNCE_HOLD_DETECT_EN
//   is defined, a long-press (held) detector.
//
// Ports:
//   clock         in   system clock, posedge
//   reset         in   asynchronous active-low reset
//   raw           in   asynchronous raw input
//   state         out  debounced active level (after polarity)
//   rose          out  one-cycle pulse on state 0->1
//   fell          out  one-cycle pulse on state 1->0
//   changed       out  rose | fell, registered
//   changed_next  out  value changed will take on the next edge (for the
//                      parent's combined any_changed register)
//   held          out  one-cycle long-press pulse, 0 without the hold macro
//
// Macro:
//   MULTICHANNEL_DEBOUNCE_HOLD_DETECT_EN  enables the hold counter
// -----------------------------------------------------------------------------
module multichannel_debounce_channel
    import multichannel_debounce_pkg::*;
#(
    parameter int   SYNC_DEPTH      = 2,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int   HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter logic POLARITY        = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic state,
    output logic rose,
    output logic fell,
    output logic changed,
    output logic changed_next,
    output logic held
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_DEPTH < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_params
        $error("multichannel_debounce_channel: SYNC_DEPTH>=2, DEBOUNCE_CYCLES>=1, HOLD_CYCLES>=1 required");
    end

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  state_q, state_d;
    logic                  rose_q, rose_d;
    logic                  fell_q, fell_d;
    logic                  changed_q, changed_d;
    logic                  sample;

    // Synchronizer shifts toward the MSB; the MSB is the settled sample.
    // Polarity is removed here so everything downstream works in "active" terms.
    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], raw};
        sample = sync_q[SYNC_DEPTH-1] ^ POLARITY;
    end

    // Debounce: any sample that agrees with the current state restarts the
    // count, so only an unbroken run of DEBOUNCE_CYCLES differing samples is
    // accepted. The count never passes CNT_LAST because acceptance clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rose_d  = 1'b0;
        fell_d  = 1'b0;
        if (sample == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = sample;
            cnt_d   = '0;
            rose_d  = sample;
            fell_d  = ~sample;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        changed_d = rose_d | fell_d;
    end

    // Sync flops reset to the inactive raw level so no spurious edge is seen
    // after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= {SYNC_DEPTH{POLARITY}};
            cnt_q     <= '0;
            state_q   <= 1'b0;
            rose_q    <= 1'b0;
            fell_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            rose_q    <= rose_d;
            fell_q    <= fell_d;
            changed_q <= changed_d;
        end
    end

    assign state        = state_q;
    assign rose         = rose_q;
    assign fell         = fell_q;
    assign changed      = changed_q;
    assign changed_next = changed_d;

`ifdef MULTICHANNEL_DEBOUNCE_HOLD_DETECT_EN
    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              held_q, held_d;

    // Hold counter saturates at HOLD_MAX, so held fires only on the single
    // HOLD_LAST->HOLD_MAX step and cannot repeat until state drops and the
    // counter is cleared.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        held_d     = 1'b0;
        if (!state_q || rose_d) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            held_d     = (hold_cnt_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt_q <= '0;
            held_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            held_q     <= held_d;
        end
    end

    assign held = held_q;
`else
    assign held = 1'b0;
`endif

endmodule

// File: rtl/multichannel_debounce.sv
// -----------------------------------------------------------------------------
// multichannel_debounce
//
// Purpose:
//   CHANNELS independent debounce channels for raw asynchronous inputs, each
//   with its own synchronizer, polarity and debounce counter, plus a single
//   registered any_changed pulse aligned with the per-channel changed pulses.
//
// Ports:
//   clock        in   system clock, posedge
//   reset        in   asynchronous active-low reset
//   raw          in   [CHANNELS] asynchronous raw inputs
//   state        out  [CHANNELS] debounced active level (1 = active)
//   rose         out  [CHANNELS] one-cycle pulse on 0->1
//   fell         out  [CHANNELS] one-cycle pulse on 1->0
//   changed      out  [CHANNELS] rose | fell
//   any_changed  out  OR of changed, same cycle as changed
//   held         out  [CHANNELS] one-cycle long-press pulse
//
// Macro:
//   MULTICHANNEL_DEBOUNCE_HOLD_DETECT_EN  enables long-press detection;
//   without it held is constant 0 and no hold counters exist.
// -----------------------------------------------------------------------------
module multichannel_debounce
    import multichannel_debounce_pkg::*;
#(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_DEPTH      = 2,
    parameter int                  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [CHANNELS-1:0] POLARITY        = {CHANNELS{1'b0}},
    parameter int                  HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] rose,
    output logic [CHANNELS-1:0] fell,
    output logic [CHANNELS-1:0] changed,
    output logic                any_changed,
    output logic [CHANNELS-1:0] held
);

    logic [CHANNELS-1:0] changed_next;
    logic                any_changed_q, any_changed_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        multichannel_debounce_channel #(
            .SYNC_DEPTH      (SYNC_DEPTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .POLARITY        (POLARITY[i])
        ) u_channel (
            .clock        (clock),
            .reset        (reset),
            .raw          (raw[i]),
            .state        (state[i]),
            .rose         (rose[i]),
            .fell         (fell[i]),
            .changed      (changed[i]),
            .changed_next (changed_next[i]),
            .held         (held[i])
        );
    end

    // OR the channels' next-cycle changed values so the registered result
    // lines up with the registered changed vector.
    always_comb begin
        any_changed_d = |changed_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            any_changed_q <= 1'b0;
        end else begin
            any_changed_q <= any_changed_d;
        end
    end

    assign any_changed = any_changed_q;

endmodule

// File: tb/tb_multichannel_debounce.sv
// -----------------------------------------------------------------------------
// tb_multichannel_debounce
//
// Self-checking bench for multichannel_debounce with CHANNELS=4, SYNC_DEPTH=2,
// DEBOUNCE_CYCLES=8, HOLD_CYCLES=32, POLARITY=4'b1000. Each scenario pushes
// the output events it expects (cycle, pulses, state) and compares them with
// the events the monitor records from the DUT. Long-press expectations follow
// MULTICHANNEL_DEBOUNCE_HOLD_DETECT_EN.
// -----------------------------------------------------------------------------
module tb_multichannel_debounce;

    localparam int         CH  = 4;
    localparam int         SD  = 2;
    localparam int         DB  = 8;
    localparam int         HC  = 32;
    localparam logic [3:0] POL = 4'b1000;
    localparam int         LAT = SD + DB - 1;

`ifdef MULTICHANNEL_DEBOUNCE_HOLD_DETECT_EN
    localparam logic [3:0] HELD_EXP = 4'b0001;
`else
    localparam logic [3:0] HELD_EXP = 4'b0000;
`endif

    typedef struct packed {
        int         cyc;
        logic [3:0] rose;
        logic [3:0] fell;
        logic [3:0] changed;
        logic       any_changed;
        logic [3:0] held;
        logic [3:0] state;
    } evt_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] raw   = POL;
    logic [3:0] state;
    logic [3:0] rose;
    logic [3:0] fell;
    logic [3:0] changed;
    logic       any_changed;
    logic [3:0] held;

    evt_t exp_q[$];
    evt_t obs_q[$];
    int   edge_cnt = 0;
    int   obs_rd   = 0;
    int   checks   = 0;
    int   failures = 0;

    multichannel_debounce #(
        .CHANNELS        (CH),
        .SYNC_DEPTH      (SD),
        .DEBOUNCE_CYCLES (DB),
        .POLARITY        (POL),
        .HOLD_CYCLES     (HC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .raw         (raw),
        .state       (state),
        .rose        (rose),
        .fell        (fell),
        .changed     (changed),
        .any_changed (any_changed),
        .held        (held)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Record every cycle on which any pulse output is active.
    always @(negedge clock) begin
        if ((|{rose, fell, changed, held}) || any_changed) begin
            obs_q.push_back('{cyc: edge_cnt, rose: rose, fell: fell, changed: changed,
                              any_changed: any_changed, held: held, state: state});
        end
    end

    function automatic evt_t make_evt(input int cyc, input logic [3:0] r, input logic [3:0] f,
                                      input logic [3:0] h, input logic [3:0] s);
        evt_t e;
        e.cyc         = cyc;
        e.rose        = r;
        e.fell        = f;
        e.changed     = r | f;
        e.any_changed = |(r | f);
        e.held        = h;
        e.state       = s;
        return e;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        int n_obs;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            raw = 4'($urandom_range(0, 15));
            checks++;
            if ({state, rose, fell, changed, any_changed, held} !== 21'd0) begin
                failures++;
                $display("[TB] FAIL reset_outputs: got state=%b rose=%b fell=%b changed=%b any=%b held=%b, expected all 0",
                         state, rose, fell, changed, any_changed, held);
            end
        end
        @(negedge clock);
        raw   = POL;
        reset = 1'b1;
        wait_cycles(20);
        checks++;
        if (state !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_release_state: got %b expected 0000", state);
        end
        n_obs = obs_q.size() - obs_rd;
        checks++;
        if (n_obs != 0) begin
            failures++;
            $display("[TB] FAIL reset_no_pulses: got %0d pulse events expected 0", n_obs);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_clean_press();
        int   e;
        int   n_exp;
        int   n_obs;
        evt_t x;
        evt_t o;
        @(negedge clock);
        raw[0] = 1'b1;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
        wait_cycles(LAT);
        checks++;
        if (state[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL press_early: state[0] got %b expected 0 one cycle before latency", state[0]);
        end
        wait_cycles(1);
        checks++;
        if ({state[0], rose[0], changed[0], any_changed} !== 4'b1111) begin
            failures++;
            $display("[TB] FAIL press_edge: got state/rose/changed/any=%b expected 1111",
                     {state[0], rose[0], changed[0], any_changed});
        end
        wait_cycles(1);
        checks++;
        if ({state[0], rose[0], changed[0], any_changed} !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL press_one_cycle: got state/rose/changed/any=%b expected 1000",
                     {state[0], rose[0], changed[0], any_changed});
        end
        wait_cycles(10);
        raw[0] = 1'b0;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000));
        wait_cycles(14);
        n_exp = exp_q.size();
        n_obs = obs_q.size() - obs_rd;
        checks++;
        if (n_obs != n_exp) begin
            failures++;
            $display("[TB] FAIL press_event_count: got %0d expected %0d", n_obs, n_exp);
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL press_event: missing, expected cyc=%0d rose=%b fell=%b state=%b", x.cyc, x.rose, x.fell, x.state);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== x) begin
                    failures++;
                    $display("[TB] FAIL press_event: got cyc=%0d rose=%b fell=%b chg=%b any=%b held=%b state=%b expected cyc=%0d rose=%b fell=%b chg=%b any=%b held=%b state=%b",
                             o.cyc, o.rose, o.fell, o.changed, o.any_changed, o.held, o.state,
                             x.cyc, x.rose, x.fell, x.changed, x.any_changed, x.held, x.state);
                end
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_bounce();
        int   e;
        int   n_exp;
        int   n_obs;
        evt_t x;
        evt_t o;
        @(negedge clock);
        raw[1] = 1'b1;
        wait_cycles(DB - 1);
        raw[1] = 1'b0;
        wait_cycles(1);
        raw[1] = 1'b1;
        wait_cycles(5);
        raw[1] = 1'b0;
        wait_cycles(12);
        checks++;
        if (state[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bounce_rejected: state[1] got %b expected 0", state[1]);
        end
        raw[1] = 1'b1;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0010, 4'b0000, 4'b0000, 4'b0010));
        wait_cycles(14);
        raw[1] = 1'b0;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0000, 4'b0010, 4'b0000, 4'b0000));
        wait_cycles(14);
        n_exp = exp_q.size();
        n_obs = obs_q.size() - obs_rd;
        checks++;
        if (n_obs != n_exp) begin
            failures++;
            $display("[TB] FAIL bounce_event_count: got %0d expected %0d", n_obs, n_exp);
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL bounce_event: missing, expected cyc=%0d rose=%b fell=%b state=%b", x.cyc, x.rose, x.fell, x.state);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== x) begin
                    failures++;
                    $display("[TB] FAIL bounce_event: got cyc=%0d rose=%b fell=%b chg=%b any=%b held=%b state=%b expected cyc=%0d rose=%b fell=%b chg=%b any=%b held=%b state=%b",
                             o.cyc, o.rose, o.fell, o.changed, o.any_changed, o.held, o.state,
                             x.cyc, x.rose, x.fell, x.changed, x.any_changed, x.held, x.state);
                end
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_active_low();
        int   e;
        int   n_exp;
        int   n_obs;
        evt_t x;
        evt_t o;
        @(negedge clock);
        raw[3] = 1'b0;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b1000, 4'b0000, 4'b0000, 4'b1000));
        wait_cycles(LAT + 1);
        checks++;
        if ({state[3], rose[3]} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL active_low_press: state/rose[3] got %b expected 11", {state[3], rose[3]});
        end
        wait_cycles(4);
        raw[3] = 1'b1;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0000, 4'b1000, 4'b0000, 4'b0000));
        wait_cycles(14);
        n_exp = exp_q.size();
        n_obs = obs_q.size() - obs_rd;
        checks++;
        if (n_obs != n_exp) begin
            failures++;
            $display("[TB] FAIL active_low_event_count: got %0d expected %0d", n_obs, n_exp);
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL active_low_event: missing, expected cyc=%0d rose=%b fell=%b state=%b", x.cyc, x.rose, x.fell, x.state);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== x) begin
                    failures++;
                    $display("[TB] FAIL active_low_event: got cyc=%0d rose=%b fell=%b chg=%b any=%b held=%b state=%b expected cyc=%0d rose=%b fell=%b chg=%b any=%b held=%b state=%b",
                             o.cyc, o.rose, o.fell, o.changed, o.any_changed, o.held, o.state,
                             x.cyc, x.rose, x.fell, x.changed, x.any_changed, x.held, x.state);
                end
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_simultaneous();
        int   e;
        int   r;
        int   n_exp;
        int   n_obs;
        evt_t x;
        evt_t o;
        @(negedge clock);
        raw[0] = 1'b1;
        raw[2] = 1'b1;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0101, 4'b0000, 4'b0000, 4'b0101));
        wait_cycles(14);
        raw[0] = 1'b0;
        raw[2] = 1'b0;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0000, 4'b0101, 4'b0000, 4'b0000));
        wait_cycles(14);
        // Reset arrives once channel 0 has counted to 5.
        raw[0] = 1'b1;
        wait_cycles(SD + 5);
        reset = 1'b0;
        wait_cycles(2);
        checks++;
        if ({state, rose, changed, any_changed} !== 13'd0) begin
            failures++;
            $display("[TB] FAIL midcount_reset: got state=%b rose=%b changed=%b any=%b expected all 0", state, rose, changed, any_changed);
        end
        reset = 1'b1;
        r = edge_cnt + 1;
        exp_q.push_back(make_evt(r + LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
        wait_cycles(LAT);
        checks++;
        if (state[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midcount_full_wait: state[0] got %b expected 0 before full latency", state[0]);
        end
        wait_cycles(5);
        raw[0] = 1'b0;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000));
        wait_cycles(14);
        n_exp = exp_q.size();
        n_obs = obs_q.size() - obs_rd;
        checks++;
        if (n_obs != n_exp) begin
            failures++;
            $display("[TB] FAIL simultaneous_event_count: got %0d expected %0d", n_obs, n_exp);
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL simultaneous_event: missing, expected cyc=%0d rose=%b fell=%b state=%b", x.cyc, x.rose, x.fell, x.state);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== x) begin
                    failures++;
                    $display("[TB] FAIL simultaneous_event: got cyc=%0d rose=%b fell=%b chg=%b any=%b held=%b state=%b expected cyc=%0d rose=%b fell=%b chg=%b any=%b held=%b state=%b",
                             o.cyc, o.rose, o.fell, o.changed, o.any_changed, o.held, o.state,
                             x.cyc, x.rose, x.fell, x.changed, x.any_changed, x.held, x.state);
                end
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_hold();
        int   e;
        int   n_exp;
        int   n_obs;
        evt_t x;
        evt_t o;
        // Long press: 50 cycles high.
        @(negedge clock);
        raw[0] = 1'b1;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
        if (HELD_EXP != 4'b0000) begin
            exp_q.push_back(make_evt(e + LAT + HC, 4'b0000, 4'b0000, HELD_EXP, 4'b0001));
        end
        wait_cycles(LAT + HC + 1);
        checks++;
        if (held !== HELD_EXP) begin
            failures++;
            $display("[TB] FAIL hold_pulse: held got %b expected %b at rose+%0d", held, HELD_EXP, HC);
        end
        wait_cycles(50 - (LAT + HC + 1));
        raw[0] = 1'b0;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000));
        wait_cycles(14);
        // Short press: 20 cycles high, no held pulse.
        raw[0] = 1'b1;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001));
        wait_cycles(20);
        raw[0] = 1'b0;
        e = edge_cnt + 1;
        exp_q.push_back(make_evt(e + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000));
        wait_cycles(HC + 15);
        n_exp = exp_q.size();
        n_obs = obs_q.size() - obs_rd;
        checks++;
        if (n_obs != n_exp) begin
            failures++;
            $display("[TB] FAIL hold_event_count: got %0d expected %0d", n_obs, n_exp);
        end
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                failures++;
                $display("[TB] FAIL hold_event: missing, expected cyc=%0d rose=%b fell=%b held=%b state=%b", x.cyc, x.rose, x.fell, x.held, x.state);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== x) begin
                    failures++;
                    $display("[TB] FAIL hold_event: got cyc=%0d rose=%b fell=%b chg=%b any=%b held=%b state=%b expected cyc=%0d rose=%b fell=%b chg=%b any=%b held=%b state=%b",
                             o.cyc, o.rose, o.fell, o.changed, o.any_changed, o.held, o.state,
                             x.cyc, x.rose, x.fell, x.changed, x.any_changed, x.held, x.state);
                end
            end
        end
        obs_rd = obs_q.size();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_active_low();
        test_simultaneous();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
